// File: rtl/cross_seq_nest.sv
// cross_seq_nest: stream expander. Each upstream beat is replayed across a
// DEPTH-level nested odometer (level 0 innermost). Every output beat carries
// the upstream payload and all level indices.
// Optional build macro CROSS_SEQ_NEST_OREG_EN adds a 2-entry skid register on
// the cd_* outputs (1-cycle latency, full throughput). Without it, the
// upstream-to-downstream path is purely combinational.
module cross_seq_nest #(
  parameter int W          = 32,
  parameter int DEPTH      = 2,
  parameter int FRAME_MODE = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DEPTH*W-1:0] cnt_ini,
  input  logic [DEPTH*W-1:0] cnt_max,
  input  logic [DEPTH*W-1:0] cnt_inc,
  input  logic [W-1:0]       uc_d0,
  input  logic [3:0]         uc_mflags,
  output logic [1:0]         cu_sflags,
  output logic [W-1:0]       cd_d0,
  output logic [DEPTH*W-1:0] cd_idx,
  output logic [3:0]         cd_mflags,
  input  logic [1:0]         dc_sflags
);

  localparam logic [0:0] ST_HEAD = 1'b0;
  localparam logic [0:0] ST_BODY = 1'b1;

  logic       uc_vld, uc_first, uc_last;
  logic       dc_abt, dc_bsy;
  logic       unused_again;

  assign uc_vld       = uc_mflags[0];
  assign uc_last      = uc_mflags[1];
  assign uc_first     = uc_mflags[2];
  assign unused_again = uc_mflags[3];
  assign dc_bsy       = dc_sflags[0];
  assign dc_abt       = dc_sflags[1];

  logic [0:0]   state_q;
  logic [W-1:0] cnt_q  [DEPTH];
  logic [W-1:0] ini_v  [DEPTH];
  logic [W-1:0] max_v  [DEPTH];
  logic [W-1:0] inc_v  [DEPTH];
  logic [W-1:0] cur_v  [DEPTH];
  logic [W-1:0] nxt_v  [DEPTH];
  logic [W:0]   sum_v  [DEPTH];
  logic [DEPTH-1:0] term;
  logic [DEPTH:0]   adv;
  logic             all_term;
  logic             head;

  logic             core_bsy;
  logic             core_acc;
  logic             abort;
  logic             core_first, core_last;
  logic [DEPTH*W-1:0] core_idx;

  assign head = (state_q == ST_HEAD);

  // Odometer: current indices, per-level terminal flags and stepped values.
  // adv[k] means every level below k is terminal, so level k moves this step.
  always_comb begin
    adv[0]   = 1'b1;
    term     = '0;
    core_idx = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      ini_v[k] = cnt_ini[k*W +: W];
      max_v[k] = cnt_max[k*W +: W];
      inc_v[k] = cnt_inc[k*W +: W];
      cur_v[k] = head ? ini_v[k] : cnt_q[k];
      sum_v[k] = {1'b0, cur_v[k]} + {1'b0, inc_v[k]};
      term[k]  = (inc_v[k] == '0) | (ini_v[k] > max_v[k]) |
                 (sum_v[k] > {1'b0, max_v[k]});
      nxt_v[k] = cur_v[k];
      if (adv[k]) nxt_v[k] = term[k] ? ini_v[k] : sum_v[k][W-1:0];
      adv[k+1] = adv[k] & term[k];
      core_idx[k*W +: W] = cur_v[k];
    end
  end

  assign all_term   = adv[DEPTH];
  assign core_acc   = uc_vld & ~core_bsy;
  assign abort      = dc_abt & uc_vld;
  assign core_first = head & ((FRAME_MODE != 0) ? uc_first : 1'b1);
  assign core_last  = all_term & ((FRAME_MODE != 0) ? uc_last : 1'b1);
  assign cu_sflags  = {dc_abt, ~((core_acc & all_term) | abort)};

  // Expansion state and counters advance on each accepted beat; abort restarts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_HEAD;
      for (int unsigned k = 0; k < DEPTH; k++) cnt_q[k] <= '0;
    end else if (abort) begin
      state_q <= ST_HEAD;
    end else if (core_acc) begin
      state_q <= all_term ? ST_HEAD : ST_BODY;
      for (int unsigned k = 0; k < DEPTH; k++) cnt_q[k] <= nxt_v[k];
    end
  end

`ifdef CROSS_SEQ_NEST_OREG_EN
  localparam int EW = W + DEPTH*W + 2;

  logic [EW-1:0] ent_q [2];
  logic [EW-1:0] core_ent;
  logic [EW-1:0] head_ent;
  logic          rd_q, wr_q;
  logic [1:0]    fill_q;
  logic          push, pop, out_vld;

  // The core sees the skid as its downstream: it stalls only when both slots hold data.
  assign core_bsy = (fill_q == 2'd2);
  assign core_ent = {uc_d0, core_idx, core_first & uc_vld, core_last & uc_vld};
  assign push     = core_acc & ~abort;
  assign out_vld  = (fill_q != 2'd0);
  assign pop      = out_vld & ~dc_bsy;
  assign head_ent = ent_q[rd_q];

  // Two-slot skid FIFO; an abort flushes whatever is still queued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_q[0] <= '0;
      ent_q[1] <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      fill_q   <= '0;
    end else if (dc_abt) begin
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      fill_q   <= '0;
    end else begin
      if (push) begin
        ent_q[wr_q] <= core_ent;
        wr_q        <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
      fill_q <= fill_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign cd_d0     = head_ent[EW-1 -: W];
  assign cd_idx    = head_ent[DEPTH*W+1 : 2];
  assign cd_mflags = {out_vld & dc_bsy, head_ent[1] & out_vld,
                      head_ent[0] & out_vld, out_vld};
`else
  assign core_bsy  = dc_bsy;
  assign cd_d0     = uc_d0;
  assign cd_idx    = core_idx;
  assign cd_mflags = {uc_vld & dc_bsy, core_first & uc_vld,
                      core_last & uc_vld, uc_vld};
`endif

endmodule

// File: tb/tb_cross_seq_nest.sv
// Self-checking bench for cross_seq_nest (combinational output build).
// Three instances share stimulus: a 32-bit frame-mode-0 unit, an 8-bit unit
// and a 32-bit frame-mode-1 unit; `sel` chooses which one is observed.
module tb_cross_seq_nest;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] ini0, max0, inc0, ini1, max1, inc1;
  logic [31:0] uc_d0;
  logic        uc_first, uc_last, uc_vld;
  logic        dc_abt, dc_bsy;

  logic [1:0]  a_su, b_su, c_su;
  logic [31:0] a_d0, c_d0;
  logic [7:0]  b_d0;
  logic [63:0] a_idx, c_idx;
  logic [15:0] b_idx;
  logic [3:0]  a_mf, b_mf, c_mf;

  cross_seq_nest #(.W(32), .DEPTH(2), .FRAME_MODE(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .cnt_ini({ini1, ini0}), .cnt_max({max1, max0}), .cnt_inc({inc1, inc0}),
    .uc_d0(uc_d0), .uc_mflags({1'b0, uc_first, uc_last, uc_vld}),
    .cu_sflags(a_su), .cd_d0(a_d0), .cd_idx(a_idx), .cd_mflags(a_mf),
    .dc_sflags({dc_abt, dc_bsy}));

  cross_seq_nest #(.W(8), .DEPTH(2), .FRAME_MODE(0)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .cnt_ini({ini1[7:0], ini0[7:0]}), .cnt_max({max1[7:0], max0[7:0]}),
    .cnt_inc({inc1[7:0], inc0[7:0]}),
    .uc_d0(uc_d0[7:0]), .uc_mflags({1'b0, uc_first, uc_last, uc_vld}),
    .cu_sflags(b_su), .cd_d0(b_d0), .cd_idx(b_idx), .cd_mflags(b_mf),
    .dc_sflags({dc_abt, dc_bsy}));

  cross_seq_nest #(.W(32), .DEPTH(2), .FRAME_MODE(1)) dutf (
    .clk(clk), .rst_n(rst_n),
    .cnt_ini({ini1, ini0}), .cnt_max({max1, max0}), .cnt_inc({inc1, inc0}),
    .uc_d0(uc_d0), .uc_mflags({1'b0, uc_first, uc_last, uc_vld}),
    .cu_sflags(c_su), .cd_d0(c_d0), .cd_idx(c_idx), .cd_mflags(c_mf),
    .dc_sflags({dc_abt, dc_bsy}));

  int          sel = 0;
  int          fm  = 0;
  logic [1:0]  o_su;
  logic [3:0]  o_mf;
  logic [31:0] o_d0, o_i0, o_i1;

  // Observation mux onto the selected instance.
  always_comb begin
    o_su = a_su; o_mf = a_mf; o_d0 = a_d0; o_i0 = a_idx[31:0]; o_i1 = a_idx[63:32];
    if (sel == 1) begin
      o_su = b_su; o_mf = b_mf; o_d0 = {24'd0, b_d0};
      o_i0 = {24'd0, b_idx[7:0]}; o_i1 = {24'd0, b_idx[15:8]};
    end else if (sel == 2) begin
      o_su = c_su; o_mf = c_mf; o_d0 = c_d0; o_i0 = c_idx[31:0]; o_i1 = c_idx[63:32];
    end
  end

  typedef struct {
    logic [31:0] d0, i0, i1;
    logic        first, last, tail;
  } beat_t;
  typedef struct {
    logic [31:0] d0;
    logic        first, last;
  } item_t;

  beat_t exp_q[$];
  item_t item_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  task automatic set_cfg(input logic [31:0] a0, b0, c0, a1, b1, c1);
    ini0 = a0; max0 = b0; inc0 = c0; ini1 = a1; max1 = b1; inc1 = c1;
  endtask

  task automatic gen_vals(input logic [31:0] ini, mx, inc, output logic [31:0] q[$]);
    logic [32:0] v;
    q.delete();
    if (inc == 0 || ini > mx) q.push_back(ini);
    else begin
      v = {1'b0, ini};
      while (v <= {1'b0, mx}) begin
        q.push_back(v[31:0]);
        v = v + {1'b0, inc};
      end
    end
  endtask

  // Reference nested expansion of one upstream item into the scoreboard.
  task automatic push_item(input logic [31:0] d0, input logic f, input logic l);
    logic [31:0] v0[$];
    logic [31:0] v1[$];
    beat_t b;
    item_t it;
    gen_vals(ini0, max0, inc0, v0);
    gen_vals(ini1, max1, inc1, v1);
    foreach (v1[j]) foreach (v0[i]) begin
      b.d0 = d0; b.i0 = v0[i]; b.i1 = v1[j];
      b.tail  = (i == v0.size() - 1) && (j == v1.size() - 1);
      b.first = (i == 0 && j == 0) && (fm != 0 ? f : 1'b1);
      b.last  = b.tail && (fm != 0 ? l : 1'b1);
      exp_q.push_back(b);
    end
    it.d0 = d0; it.first = f; it.last = l;
    item_q.push_back(it);
  endtask

  // Drives held items, applies busy/abort windows and scores each cycle.
  task automatic drain(input int budget, input int bsy_lo, input int bsy_hi,
                       input int abt_at, input bit partial, input string nm);
    int    c;
    beat_t e;
    logic [101:0] got, want;
    c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      if (item_q.size() != 0) begin
        uc_vld = 1'b1; uc_d0 = item_q[0].d0;
        uc_first = item_q[0].first; uc_last = item_q[0].last;
      end else uc_vld = 1'b0;
      dc_bsy = (c >= bsy_lo && c <= bsy_hi);
      dc_abt = (c == abt_at);
      @(negedge clk);
      e    = exp_q[0];
      got  = {o_mf, o_su, o_d0, o_i1, o_i0};
      want = {dc_bsy, e.first, e.last, 1'b1, dc_abt,
              (dc_bsy | (~dc_abt & ~e.tail)), e.d0, e.i1, e.i0};
      n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL %s cyc%0d: got mf=%b su=%b d0=%h l1=%0d l0=%0d, want mf=%b su=%b d0=%h l1=%0d l0=%0d",
                 nm, c, got[101:98], got[97:96], got[95:64], got[63:32], got[31:0],
                 want[101:98], want[97:96], want[95:64], want[63:32], want[31:0]);
      end
      if (dc_abt) begin
        while (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          if (e.tail) break;
        end
        void'(item_q.pop_front());
      end else if (!dc_bsy) begin
        e = exp_q.pop_front();
        if (e.tail) void'(item_q.pop_front());
      end
      @(posedge clk); #1;
      c++;
    end
    if (!partial && exp_q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL %s budget: got %0d beats outstanding, want 0", nm, exp_q.size());
    end
    uc_vld = 1'b0; dc_bsy = 1'b0; dc_abt = 1'b0;
  endtask

  task automatic test_reset();
    logic [73:0] got;
    sel = 0; fm = 0;
    set_cfg(7, 9, 1, 3, 9, 1);
    #1;
    got = {a_mf, a_su, a_idx};
    n_vec++;
    if (got !== {4'b0000, 2'b01, 32'd3, 32'd7}) begin
      n_err++; $display("FAIL reset_idle: got %h want %h", got, {4'b0000, 2'b01, 32'd3, 32'd7});
    end
    dc_abt = 1'b1; #1;
    n_vec++;
    if (a_su !== 2'b11) begin n_err++; $display("FAIL reset_abt: got %b want 11", a_su); end
    dc_abt = 1'b0; uc_vld = 1'b1; #1;
    got = {a_mf, a_su, a_idx};
    n_vec++;
    if (got !== {4'b0101, 2'b01, 32'd3, 32'd7}) begin
      n_err++; $display("FAIL reset_vld: got %h want %h", got, {4'b0101, 2'b01, 32'd3, 32'd7});
    end
    uc_vld = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_nest();
    sel = 0; fm = 0;
    set_cfg(0, 2, 1, 0, 1, 1);
    push_item(32'hA5, 1'b1, 1'b1);
    drain(20, -1, -1, -1, 1'b0, "nest");
  endtask

  task automatic test_no_wrap();
    sel = 1; fm = 0;
    set_cfg(250, 255, 4, 0, 0, 1);
    push_item(32'h5A, 1'b1, 1'b1);
    drain(10, -1, -1, -1, 1'b0, "no_wrap");
  endtask

  task automatic test_backpressure();
    sel = 0; fm = 0;
    set_cfg(0, 2, 1, 0, 1, 1);
    push_item(32'h3C, 1'b1, 1'b1);
    drain(20, 2, 4, -1, 1'b0, "backpressure");
  endtask

  task automatic test_abort();
    sel = 0; fm = 0;
    set_cfg(0, 2, 1, 0, 1, 1);
    push_item(32'h11, 1'b1, 1'b1);
    push_item(32'h22, 1'b1, 1'b1);
    drain(30, -1, -1, 3, 1'b0, "abort");
  endtask

  task automatic test_frame();
    sel = 2; fm = 1;
    set_cfg(0, 2, 1, 0, 0, 1);
    push_item(32'h1, 1'b1, 1'b0);
    push_item(32'h2, 1'b0, 1'b1);
    drain(20, -1, -1, -1, 1'b0, "frame");
    fm = 0;
  endtask

  task automatic test_back_to_back();
    sel = 0; fm = 0;
    set_cfg(5, 1, 0, 5, 1, 0);
    for (int i = 0; i < 4; i++) push_item(32'hB0 + i, 1'b1, 1'b1);
    drain(4, -1, -1, -1, 1'b0, "back_to_back");
  endtask

  task automatic test_reset_mid();
    logic [69:0] got;
    sel = 0; fm = 0;
    set_cfg(0, 2, 1, 0, 1, 1);
    push_item(32'h77, 1'b1, 1'b1);
    drain(2, -1, -1, -1, 1'b1, "reset_mid_pre");
    uc_vld = 1'b1; uc_d0 = 32'h77; uc_first = 1'b1; uc_last = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    got = {a_mf, a_d0[1:0], a_idx};
    n_vec++;
    if (got !== {4'b0101, 2'b11, 64'd0}) begin
      n_err++; $display("FAIL reset_mid_hold: got %h want %h", got, {4'b0101, 2'b11, 64'd0});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete(); item_q.delete();
    push_item(32'h77, 1'b1, 1'b1);
    drain(20, -1, -1, -1, 1'b0, "reset_mid_restart");
  endtask

  initial begin
    rst_n = 1'b0; uc_vld = 1'b0; uc_first = 1'b0; uc_last = 1'b0;
    uc_d0 = '0; dc_abt = 1'b0; dc_bsy = 1'b0;
    test_reset();
    test_nest();
    test_no_wrap();
    test_backpressure();
    test_abort();
    test_frame();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
